adc_spi_sampler: RTL and testbench
==================================

// Module: adc_spi_sampler
// PURPOSE
// - Front-end of the current-control loop: drives a 12-bit serial ADC (16-clock frame, 4 leading zeros, MSB first)
//   at a fixed sample rate and presents each result as a parallel word plus a sample-rate strobe.
// - Feeds the ADC-to-error stage, which latches ADC when clkFs is high and waits for clkFs to fall before re-arming.
// - clkFs is therefore a multi-cycle level, not a 1-cycle pulse, and ADC is stable for its whole high window.
// PARAMETERS
// - CLK_DIV  4     clk cycles per SCLK half-period (SCLK = clk/(2*CLK_DIV)); >= 1
// - FS_DIV   1000  clk cycles per sample period (50 MHz clk -> 50 kS/s)
// - FS_HIGH  8     clk cycles clkFs stays high per valid sample; >= 6 (downstream FSM needs 5)
// - Legal set: FS_DIV >= 33*CLK_DIV + FS_HIGH + 4; the bench asserts this at time 0.
// PORTS
// - clk        in   1   system clock, all logic on rising edge
// - rst        in   1   asynchronous reset, active-high
// - en         in   1   1 = run sampling; sampled at each period start
// - adc_sdo    in   1   ADC serial data out
// - adc_cs_n   out  1   ADC chip select, active low
// - adc_sclk   out  1   ADC serial clock, idles high
// - ADC        out  12  last valid conversion result, unsigned
// - clkFs      out  1   sample strobe, high FS_HIGH cycles per valid sample
// - frame_err  out  1   1 = last frame had a nonzero leading bit
// BEHAVIOUR
// - Reset (async, effective immediately, mid-frame included): adc_cs_n=1, adc_sclk=1, ADC=0, clkFs=0,
//   frame_err=0, period counter=0, FSM=IDLE; partial frame discarded. All outputs are registered.
// - Period counter: counts 0..FS_DIV-1 and wraps; it runs regardless of en. t=0 is the cycle count==0.
// - FSM IDLE: at t=0 with en=1, go to SETUP; otherwise stay.
// - FSM SETUP: t=1..CLK_DIV; adc_cs_n=0, adc_sclk=1.
// - FSM SHIFT: 16 bits. Each bit: CLK_DIV cycles sclk=0, then CLK_DIV cycles sclk=1.
//   adc_sdo is shifted into a 16-bit register in the same cycle sclk is driven 0->1. Bit 15 is the first bit.
// - FSM DONE: 1 cycle; adc_cs_n=1, sclk=1, frame checked.
// - Frame check, bits[15:12]==0 (good): next cycle ADC<=bits[11:0], frame_err<=0, clkFs<=1.
//   clkFs rises at t=33*CLK_DIV+2 (134 at defaults) and stays high exactly FS_HIGH cycles.
// - Frame check, bad: ADC holds, clkFs stays 0, frame_err<=1 until the next good frame.
// - FSM returns to IDLE after the strobe window, or right after DONE on a bad frame.
// - en falling mid-frame: the current frame completes normally, including its strobe. No new frame starts until en=1 at a t=0.
// - en rising mid-period: the first frame starts at the next t=0.
// - ADC stays constant from clkFs rise until the next good frame's update, so it is constant while clkFs=1.
// - clkFs is always low for at least one cycle between windows.
// - adc_cs_n stays high >= FS_DIV-33*CLK_DIV-2 cycles between frames (ADC quiet time).
// TESTING
// - Defaults, adc_sdo model returns 0x0ABC -> ADC=0xABC, clkFs rises at t=134, high 8 cycles, frame_err=0.
// - Model returns 0x0FFF, then 0x0000 -> ADC=0xFFF, then 0x000; 16 sclk rising edges per frame, sclk period 8 clk.
// - Model returns 0x8123 after a good 0x0ABC -> frame_err=1, ADC stays 0xABC, no clkFs; next good frame clears frame_err.
// - Free-run 5 periods -> clkFs rising edges exactly 1000 cycles apart; adc_cs_n low 4+128 cycles per frame.
// - en dropped at t=50 -> frame completes with clkFs at t=134; adc_cs_n stays high afterwards; en=1 restarts at next t=0.
// - rst pulsed at t=60 -> same cycle adc_cs_n=1, sclk=1, ADC=0, clkFs=0; after release first frame at counter 0.

Source files
------------

// File: rtl/adc_spi_sampler_if.sv
// ADC sampler bus: control input, serial ADC pins and the parallel sample output.
// master = sampler side, slave = ADC/consumer side.
// clk and rst are kept outside the interface.
interface adc_spi_sampler_if;
   logic        en;
   logic        adc_sdo;
   logic        adc_cs_n;
   logic        adc_sclk;
   logic [11:0] ADC;
   logic        clkFs;
   logic        frame_err;

   modport master (
      input  en, adc_sdo,
      output adc_cs_n, adc_sclk, ADC, clkFs, frame_err
   );

   modport slave (
      output en, adc_sdo,
      input  adc_cs_n, adc_sclk, ADC, clkFs, frame_err
   );
endinterface

// File: rtl/adc_spi_sampler.sv
// Drives a 12-bit serial ADC (16-clock frame, 4 leading zeros) once per FS_DIV cycles
// and presents the result as ADC plus a FS_HIGH-cycle clkFs level strobe.
// Every output is registered; there is no backpressure, and a sample is produced each period while en=1.
module adc_spi_sampler #(
   parameter int CLK_DIV = 4,
   parameter int FS_DIV  = 1000,
   parameter int FS_HIGH = 8
) (
   input  logic               clk,
   input  logic               rst,
   adc_spi_sampler_if.master  bus
);

   localparam int CNT_W = $clog2(FS_DIV);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FSH_W = $clog2(FS_HIGH);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, STROBE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [DIV_W-1:0]   div_cnt, div_nxt;
   logic               half, half_nxt;
   logic [3:0]         bit_cnt, bit_nxt;
   logic [15:0]        sh, sh_nxt;
   logic [FSH_W-1:0]   fs_cnt, fs_cnt_nxt;
   logic               cs_n_q, cs_n_nxt;
   logic               sclk_q, sclk_nxt;
   logic [11:0]        adc_q, adc_nxt;
   logic               fs_q, fs_nxt;
   logic               err_q, err_nxt;
   logic               div_last;

   assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

   // Free-running sample-period counter; t=0 is where a new frame may start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (cnt == CNT_W'(FS_DIV - 1))
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // State and output registers; all next values come from the decode below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         div_cnt <= '0;
         half    <= 1'b0;
         bit_cnt <= '0;
         sh      <= '0;
         fs_cnt  <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         adc_q   <= '0;
         fs_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         half    <= half_nxt;
         bit_cnt <= bit_nxt;
         sh      <= sh_nxt;
         fs_cnt  <= fs_cnt_nxt;
         cs_n_q  <= cs_n_nxt;
         sclk_q  <= sclk_nxt;
         adc_q   <= adc_nxt;
         fs_q    <= fs_nxt;
         err_q   <= err_nxt;
      end
   end

   // Frame sequencing: outputs are decoded one cycle early so the pins come straight from flops.
   always_comb begin
      state_nxt  = state;
      div_nxt    = div_cnt;
      half_nxt   = half;
      bit_nxt    = bit_cnt;
      sh_nxt     = sh;
      fs_cnt_nxt = fs_cnt;
      cs_n_nxt   = 1'b1;
      sclk_nxt   = 1'b1;
      adc_nxt    = adc_q;
      fs_nxt     = 1'b0;
      err_nxt    = err_q;
      case (state)
         IDLE: begin
            if (cnt == '0 && bus.en) begin
               state_nxt = SETUP;
               div_nxt   = '0;
               cs_n_nxt  = 1'b0;
            end
         end
         SETUP: begin
            cs_n_nxt = 1'b0;
            if (div_last) begin
               state_nxt = SHIFT;
               div_nxt   = '0;
               half_nxt  = 1'b0;
               bit_nxt   = '0;
               sclk_nxt  = 1'b0;
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         SHIFT: begin
            cs_n_nxt = 1'b0;
            sclk_nxt = half;
            if (div_last) begin
               div_nxt = '0;
               if (!half) begin
                  // Capture on the cycle sclk is driven high; data has been stable for the whole low phase.
                  half_nxt = 1'b1;
                  sh_nxt   = {sh[14:0], bus.adc_sdo};
                  sclk_nxt = 1'b1;
               end else if (bit_cnt == 4'd15) begin
                  state_nxt = DONE;
                  cs_n_nxt  = 1'b1;
                  sclk_nxt  = 1'b1;
               end else begin
                  bit_nxt  = bit_cnt + 1'b1;
                  half_nxt = 1'b0;
                  sclk_nxt = 1'b0;
               end
            end else begin
               div_nxt = div_cnt + 1'b1;
            end
         end
         DONE: begin
            // A nonzero leading bit means a corrupted frame: keep the old sample and suppress the strobe.
            if (sh[15:12] == 4'd0) begin
               state_nxt  = STROBE;
               adc_nxt    = sh[11:0];
               err_nxt    = 1'b0;
               fs_nxt     = 1'b1;
               fs_cnt_nxt = '0;
            end else begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         STROBE: begin
            if (fs_cnt == FSH_W'(FS_HIGH - 1)) begin
               state_nxt = IDLE;
            end else begin
               fs_cnt_nxt = fs_cnt + 1'b1;
               fs_nxt     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.adc_cs_n  = cs_n_q;
   assign bus.adc_sclk  = sclk_q;
   assign bus.ADC       = adc_q;
   assign bus.clkFs     = fs_q;
   assign bus.frame_err = err_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench for adc_spi_sampler: an ADC model serves queued words,
// expected results are queued as frames are scheduled and popped one cycle after each frame ends.
// Covers reset, good/bad frames, free-run spacing, en gating and mid-frame reset.
module tb_adc_spi_sampler;

   localparam int CLK_DIV = 4;
   localparam int FS_DIV  = 1000;
   localparam int FS_HIGH = 8;
   localparam int RISE_T  = 33 * CLK_DIV + 2;

   typedef struct {
      logic [11:0] adc;
      logic        err;
      logic        strobe;
   } exp_t;

   logic clk;
   logic rst;
   adc_spi_sampler_if bus();

   adc_spi_sampler #(.CLK_DIV(CLK_DIV), .FS_DIV(FS_DIV), .FS_HIGH(FS_HIGH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   exp_t        exp_q[$];
   logic [15:0] model_q[$];
   logic [11:0] last_good = '0;
   bit          spacing_on = 0;
   int          tb_t = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      assert (FS_DIV >= 33 * CLK_DIV + FS_HIGH + 4) else $fatal(1, "illegal parameter set");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
   endtask

   // Bench's own copy of the sample-period phase.
   always @(posedge clk or posedge rst) begin
      if (rst) tb_t <= 0;
      else     tb_t <= (tb_t == FS_DIV - 1) ? 0 : tb_t + 1;
   end

   // ADC model: MSB on chip-select fall, next bit after each sclk rise.
   logic [15:0] cur_word = '0;
   int          bit_idx = 15;
   int          sclk_rises = 0;
   time         first_rise = 0, last_rise_t = 0;

   always @(negedge bus.adc_cs_n) begin
      cur_word    = (model_q.size() > 0) ? model_q.pop_front() : 16'h0000;
      bit_idx     = 15;
      sclk_rises  = 0;
      bus.adc_sdo = cur_word[15];
   end

   always @(posedge bus.adc_sclk) begin
      if (!bus.adc_cs_n) begin
         sclk_rises++;
         if (sclk_rises == 1) first_rise = $time;
         last_rise_t = $time;
         if (bit_idx > 0) bit_idx--;
         bus.adc_sdo = cur_word[bit_idx];
      end
   end

   task automatic send_frame(input logic [15:0] w);
      exp_t e;
      model_q.push_back(w);
      if (w[15:12] == 4'd0) begin
         e.adc = w[11:0]; e.err = 1'b0; e.strobe = 1'b1;
         last_good = w[11:0];
      end else begin
         e.adc = last_good; e.err = 1'b1; e.strobe = 1'b0;
      end
      exp_q.push_back(e);
   endtask

   // Monitor: frame-length checks at chip-select rise, scoreboard pop one cycle later, strobe shape checks.
   bit          prev_cs = 1, prev_fs = 0, pend = 0, rise_ok = 0, adc_moved = 0;
   int          cs_low = 0, fs_hi = 0;
   longint      cyc = 0, rise_cyc = 0;
   logic [11:0] adc_at_rise = '0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         prev_cs = 1; prev_fs = 0; cs_low = 0; fs_hi = 0; pend = 0; rise_ok = 0;
      end else begin
         if (!bus.adc_cs_n) cs_low++;
         if (!prev_cs && bus.adc_cs_n) begin
            check("cs_low_len", cs_low, 33 * CLK_DIV);
            check("sclk_rises", sclk_rises, 16);
            check("sclk_span", int'((last_rise_t - first_rise) / 10), 15 * 2 * CLK_DIV);
            cs_low = 0;
            pend = 1;
         end else if (pend) begin
            pend = 0;
            if (exp_q.size() == 0) begin
               check("sb_underflow", 0, 1);
            end else begin
               e = exp_q.pop_front();
               check("adc_value", int'(bus.ADC), int'(e.adc));
               check("frame_err", int'(bus.frame_err), int'(e.err));
               check("clkfs_present", int'(bus.clkFs), int'(e.strobe));
               if (e.strobe) check("clkfs_rise_t", tb_t, RISE_T);
            end
         end
         if (bus.clkFs && !prev_fs) begin
            adc_at_rise = bus.ADC;
            adc_moved = 0;
            fs_hi = 0;
            if (spacing_on && rise_ok) check("clkfs_spacing", int'(cyc - rise_cyc), FS_DIV);
            rise_cyc = cyc;
            rise_ok = 1;
         end
         if (bus.clkFs) begin
            fs_hi++;
            if (bus.ADC != adc_at_rise) adc_moved = 1;
         end
         if (!bus.clkFs && prev_fs) begin
            check("clkfs_high_len", fs_hi, FS_HIGH);
            check("adc_stable", int'(adc_moved), 0);
         end
         if (!spacing_on) rise_ok = 0;
         prev_cs = bus.adc_cs_n;
         prev_fs = bus.clkFs;
      end
   end

   task automatic wait_t(input int v);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tb_t != v && n < 2 * FS_DIV);
      if (tb_t != v) check("wait_t_timeout", tb_t, v);
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || pend) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs_n"}, int'(bus.adc_cs_n), 1);
      check({tag, "_sclk"}, int'(bus.adc_sclk), 1);
      check({tag, "_adc"}, int'(bus.ADC), 0);
      check({tag, "_clkfs"}, int'(bus.clkFs), 0);
      check({tag, "_ferr"}, int'(bus.frame_err), 0);
   endtask

   initial begin
      int lows;
      rst = 1;
      bus.en = 0;
      bus.adc_sdo = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_init");

      // Five free-running good periods, ending on 0x0ABC.
      send_frame(16'h0ABC);
      send_frame(16'h0FFF);
      send_frame(16'h0000);
      send_frame(16'h0555);
      send_frame(16'h0ABC);
      spacing_on = 1;
      bus.en = 1;
      rst = 0;
      wait_drain(6 * FS_DIV);
      spacing_on = 0;

      // Bad frame holds ADC and sets frame_err; the next good frame clears it.
      send_frame(16'h8123);
      send_frame(16'h0ABC);
      wait_drain(3 * FS_DIV);
      bus.en = 0;

      // en raised mid-period waits for t=0; dropped at t=50 the frame still completes.
      send_frame(16'h0321);
      wait_t(500);
      bus.en = 1;
      wait_t(50);
      bus.en = 0;
      wait_drain(2 * FS_DIV);
      lows = 0;
      for (int i = 0; i < FS_DIV; i++) begin
         @(negedge clk);
         if (!bus.adc_cs_n) lows++;
      end
      check("cs_idle_after_en_drop", lows, 0);
      send_frame(16'h0777);
      wait_t(500);
      bus.en = 1;
      wait_drain(3 * FS_DIV);
      bus.en = 0;

      // Reset in the middle of a frame, then restart from counter 0.
      send_frame(16'h0BAD);
      wait_t(500);
      bus.en = 1;
      wait_t(60);
      #2 rst = 1;
      #1 check_reset_outputs("rst_mid");
      repeat (3) @(negedge clk);
      exp_q.delete();
      model_q.delete();
      last_good = '0;
      send_frame(16'h0123);
      rst = 0;
      wait_drain(2 * FS_DIV);
      bus.en = 0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
